// File: rtl/byte_packer.sv
// Pairs a byte stream into 16-bit words (first byte high) and buffers them in a FWFT FIFO.
// Latency: a completing byte on cycle N shows the word on dout at N+1; a pop shows the next head at N+1.
// Backpressure: full = buffer full while a high byte is held; bytes written while full are dropped (overflow).
// Optional feature macro: PACKER_TIMEOUT_EN discards a held half-word after TIMEOUT idle cycles.
module byte_packer #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  din,
  output logic        full,
  input  logic        flush,
  input  logic        rd_en,
  output logic [15:0] dout,
  output logic        empty,
  output logic        pending,
  output logic        overflow,
  output logic        underflow,
  output logic        timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Elaboration-time sanity checks on the parameters.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("byte_packer: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("byte_packer: TIMEOUT must be at least 1");
  end

  typedef enum logic {IDLE = 1'b0, HALF = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic [15:0]     mem_q [DEPTH];

  logic            buf_full;
  logic            accept;
  logic            pop;
  logic            push;
  logic [15:0]     push_dat;
  logic            tmo_hit;

  assign buf_full = (count_q == CW'(DEPTH));
  assign accept   = wr_en && !full;
  assign pop      = rd_en && !empty;

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  // The last idle cycle before the limit discards the held byte unless a byte arrives in it.
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and push decision; a byte is always processed before flush.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    push     = 1'b0;
    push_dat = 16'h0000;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (flush && !buf_full) begin
            push     = 1'b1;
            push_dat = {din, PAD_BYTE};
          end else begin
            hi_d    = din;
            state_d = HALF;
          end
        end
      end
      HALF: begin
        // accept implies room: HALF with a full buffer is exactly the full condition.
        if (accept) begin
          push     = 1'b1;
          push_dat = {hi_q, din};
          state_d  = IDLE;
        end else if (flush && !buf_full) begin
          push     = 1'b1;
          push_dat = {hi_q, PAD_BYTE};
          state_d  = IDLE;
        end else if (tmo_hit) begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs derived from the registered state and buffer occupancy.
  always_comb begin
    pending   = (state_q == HALF);
    full      = buf_full && (state_q == HALF);
    empty     = (count_q == '0);
    dout      = empty ? 16'h0000 : mem_q[rd_ptr_q];
    overflow  = overflow_q;
    underflow = underflow_q;
  end

  // Pointer, count and sticky-flag next values.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    overflow_d  = overflow_q  | (wr_en && full);
    underflow_d = underflow_q | (rd_en && empty);
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q        <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      hi_q        <= hi_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Word storage; contents need no reset because dout is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

`ifdef PACKER_TIMEOUT_EN
  // Idle counter runs only while a half-word stays held without a new byte.
  always_comb begin
    tmo_cnt_d = '0;
    timeout_d = 1'b0;
    if ((state_q == HALF) && !accept && (state_d == HALF)) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
    if ((state_q == HALF) && !accept && !(flush && !buf_full) && tmo_hit) begin
      timeout_d = 1'b1;
    end
  end

  // Timeout counter and registered one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/byte_packer.md
# byte_packer

Single-clock 8-to-16-bit width converter: the receive-side counterpart of the 16-to-8 sample serializer. Accepts a byte stream with FIFO-style write strobes, pairs consecutive bytes into 16-bit words (first byte → [15:8], second byte → [7:0], matching the serializer's MSB-first byte order), and buffers completed words in a small first-word-fall-through FIFO. It sits between the byte-wide command/loopback link and 16-bit consumers such as the sample checker and register decoder.

## Interface
- `DEPTH`, 4: word buffer depth; power of two, ≥2.
- `PAD_BYTE`, 8'h00: low byte inserted by `flush`.
- `TIMEOUT`, 255: idle cycles before a held half-word is discarded. Used only with `PACKER_TIMEOUT_EN`.

- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: byte write strobe.
- `din` in 8: write byte.
- `full` out 1: write back-pressure.
- `flush` in 1: pad and push a held half-word.
- `rd_en` in 1: pop head word.
- `dout` out 16: head word (FWFT).
- `empty` out 1: no word available.
- `pending` out 1: high byte held, awaiting low byte.
- `overflow` out 1: sticky; `wr_en` seen while `full`.
- `underflow` out 1: sticky; `rd_en` seen while `empty`.
- `timeout` out 1: one-cycle pulse when a half-word is discarded.

## Operation
- Reset values: `empty`=1, `full`=0, `dout`=16'h0000, `pending`=0, `overflow`=0, `underflow`=0, `timeout`=0. Buffer pointers, count and timeout counter are cleared. Reset mid-operation discards held bytes and buffered words.
- Pack FSM, two states:
  - IDLE (`pending`=0): an accepted byte is stored as the high byte. Next state is HALF.
  - HALF (`pending`=1): an accepted byte pushes {hi, din} into the buffer. Next state is IDLE.
- `full` = (count == DEPTH) && `pending`. `full` is combinational from state. A same-cycle `rd_en` gives no bypass.
- In IDLE, a byte is accepted even when the buffer is full.
- `wr_en` while `full`: the byte is dropped, state is unchanged, and `overflow` is set.
- `rd_en` while `!empty`: pops the head word. `rd_en` while `empty`: ignored, and `underflow` is set. Both sticky flags clear only on `rst`.
- `dout` = head entry when `!empty`, and 16'h0000 when `empty`.
- `flush`:
  - In HALF with count < DEPTH: pushes {hi, PAD_BYTE} and moves to IDLE.
  - In HALF with the buffer full: ignored. The caller retries.
  - In IDLE: no-op.
- `flush` and `wr_en` in the same cycle: the byte is processed first.
  - From IDLE, {din, PAD_BYTE} is pushed if count < DEPTH, and the state stays IDLE. If the buffer is full, the byte is held and the state moves to HALF.
  - From HALF, the byte completes the word normally and `flush` has no further effect.
- Push and pop in the same cycle: count is unchanged. This is legal at any count where the push is accepted.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

## Timing
- A completing byte on cycle N gives `empty`=0 with the word on `dout` at cycle N+1.
- A pop on cycle N shows the next word on `dout`, or `empty`=1, at cycle N+1.
- `full`, `pending`, `overflow` and `underflow` update at the clock edge following the causing event.
- `timeout` is registered and asserts for exactly one cycle.

## Configuration
- `PACKER_TIMEOUT_EN` defined:
  - A counter clears on every accepted byte and on entry to IDLE, and increments each cycle spent in HALF with no accepted byte.
  - When it reaches TIMEOUT, the held byte is discarded, the FSM returns to IDLE and `timeout` pulses on the next cycle.
  - A byte accepted in the cycle the count reaches TIMEOUT wins: the word completes and no timeout occurs.
- `PACKER_TIMEOUT_EN` undefined: no counter is built, `timeout` is tied to 0, and HALF is held indefinitely.

## Test plan
- Basic pack and read: write 8'hAB, 8'hCD, 8'h12, 8'h34 on consecutive cycles → `dout`=16'hABCD, then 16'h1234 after one `rd_en`. `empty` falls one cycle after the second byte. `pending` toggles 1,0,1,0.
- Full and overflow: with DEPTH=4 and no reads, write 9 bytes → `full`=1 after the 9th. A 10th byte (8'hEE) is dropped and `overflow`=1. After one `rd_en`, `full`=0, and writing 8'h77 pushes {9th byte, 8'h77}.
- Underflow: `rd_en` after reset → `underflow`=1, `empty` stays 1, `dout`=0.
- Flush: write 8'h5A, then `flush` → `dout`=16'h5A00 with PAD_BYTE=0, and `pending`=0. `flush` together with `wr_en` carrying 8'h3C in IDLE → 16'h3C00.
- Timeout (with `PACKER_TIMEOUT_EN`, TIMEOUT=8): write 8'h99, then idle → `timeout` pulses once, `pending`=0 and `empty` stays 1. A byte arriving on the 8th idle cycle completes the word and no pulse occurs.
- Reset mid-operation: with 3 words buffered and `pending`=1, assert `rst` → all outputs return to their reset values. The next two bytes form the first word.
